// File: rtl/judge_display_sched_pkg.sv
// Shared definitions for the judge display path.
// Holds the 2-bit judge encoding (shared with the display decoder and the
// judge generators) and the scheduler FSM state encoding.
package judge_display_sched_pkg;

    typedef logic [1:0] judge_t;

    localparam judge_t JUDGE_IDLE    = 2'b00;
    localparam judge_t JUDGE_MISS    = 2'b01;
    localparam judge_t JUDGE_NORMAL  = 2'b10;
    localparam judge_t JUDGE_PERFECT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/judge_display_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches the request vector upward from i_ptr, wrapping past the top lane,
// and reports the first requesting lane. The pointer register is owned by
// the caller.
// Ports:
//   i_req      per-lane request vector
//   i_ptr      lane index where the search starts
//   o_gnt_vld  at least one request is present
//   o_gnt_idx  granted lane index (0 when o_gnt_vld is low)
module judge_display_sched_rr_arbiter #(
    parameter int N_LANES = 4,
    parameter int LANE_W  = $clog2(N_LANES)
) (
    input  logic [N_LANES-1:0] i_req,
    input  logic [LANE_W-1:0]  i_ptr,
    output logic               o_gnt_vld,
    output logic [LANE_W-1:0]  o_gnt_idx
);

    int                idx;
    logic [LANE_W-1:0] idx_w;

    always_comb begin
        o_gnt_vld = 1'b0;
        o_gnt_idx = '0;
        idx       = 0;
        idx_w     = '0;
        for (int i = 0; i < N_LANES; i++) begin
            // Wrap by subtraction so N_LANES need not be a power of two.
            idx = int'(i_ptr) + i;
            if (idx >= N_LANES) begin
                idx = idx - N_LANES;
            end
            idx_w = LANE_W'(idx);
            if (!o_gnt_vld && i_req[idx_w]) begin
                o_gnt_vld = 1'b1;
                o_gnt_idx = idx_w;
            end
        end
    end

endmodule

// File: rtl/judge_display_sched.sv
// Schedules per-lane judge events onto the single shared judge display.
// Each lane keeps one pending slot holding its latest event. Slots are
// granted round-robin; a granted judge is shown for HOLD_CYCLES cycles,
// followed by GAP_CYCLES blank cycles (none when GAP_CYCLES is 0).
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_clear      synchronous clear of slots, pointer, timer and display
//   i_judge_vld  per-lane one-cycle event strobe
//   i_judge      per-lane judge codes, lane k at [2k+1:2k]
//   o_judge      judge code to the display decoder, 00 when blank
//   o_lane       lane currently shown, 0 when not showing
//   o_busy       high while showing or in the blank gap
//   o_drop       one-cycle pulse when a pending unshown event was overwritten
module judge_display_sched
    import judge_display_sched_pkg::*;
#(
    parameter int N_LANES     = 4,
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    localparam int LANE_W     = $clog2(N_LANES),
    localparam int CNT_W      = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clear,
    input  logic [N_LANES-1:0]     i_judge_vld,
    input  logic [2*N_LANES-1:0]   i_judge,
    output logic [1:0]             o_judge,
    output logic [LANE_W-1:0]      o_lane,
    output logic                   o_busy,
    output logic                   o_drop
);

    sched_state_e              state_q, state_d;
    logic [CNT_W-1:0]          timer_q, timer_d;
    logic [LANE_W-1:0]         ptr_q, ptr_d;
    logic [N_LANES-1:0]        slot_vld_q, slot_vld_d;
    logic [N_LANES-1:0][1:0]   slot_code_q, slot_code_d;
    judge_t                    judge_q, judge_d;
    logic [LANE_W-1:0]         lane_q, lane_d;
    logic                      busy_q, busy_d;
    logic                      drop_q, drop_d;

    logic                      gnt_vld;
    logic [LANE_W-1:0]         gnt_idx;
    logic                      do_grant;

    judge_display_sched_rr_arbiter #(
        .N_LANES (N_LANES),
        .LANE_W  (LANE_W)
    ) u_arb (
        .i_req     (slot_vld_q),
        .i_ptr     (ptr_q),
        .o_gnt_vld (gnt_vld),
        .o_gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        ptr_d       = ptr_q;
        slot_vld_d  = slot_vld_q;
        slot_code_d = slot_code_q;
        judge_d     = judge_q;
        lane_d      = lane_q;
        drop_d      = 1'b0;
        do_grant    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    do_grant = 1'b1;
                end
            end
            ST_SHOW: begin
                if (timer_q == '0) begin
                    if (GAP_CYCLES > 0) begin
                        judge_d = JUDGE_IDLE;
                        lane_d  = '0;
                        timer_d = CNT_W'(GAP_CYCLES - 1);
                        state_d = ST_GAP;
                    end else if (gnt_vld) begin
                        // Back-to-back mode: hand the display straight over.
                        do_grant = 1'b1;
                    end else begin
                        judge_d = JUDGE_IDLE;
                        lane_d  = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (timer_q == '0) begin
                    if (gnt_vld) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_grant) begin
            judge_d = slot_code_q[gnt_idx];
            lane_d  = gnt_idx;
            ptr_d   = (gnt_idx == LANE_W'(N_LANES - 1)) ? '0 : gnt_idx + 1'b1;
            timer_d = CNT_W'(HOLD_CYCLES - 1);
            state_d = ST_SHOW;
        end

        // The granted slot is freed first, so a new event on the lane being
        // granted lands in an empty slot and does not count as a drop.
        for (int k = 0; k < N_LANES; k++) begin
            if (do_grant && (gnt_idx == LANE_W'(k))) begin
                slot_vld_d[k] = 1'b0;
            end
            if (i_judge_vld[k] && (i_judge[2*k +: 2] != JUDGE_IDLE)) begin
                if (slot_vld_d[k]) begin
                    drop_d = 1'b1;
                end
                slot_vld_d[k]  = 1'b1;
                slot_code_d[k] = i_judge[2*k +: 2];
            end
        end

        if (i_clear) begin
            state_d     = ST_IDLE;
            timer_d     = '0;
            ptr_d       = '0;
            slot_vld_d  = '0;
            slot_code_d = '0;
            judge_d     = JUDGE_IDLE;
            lane_d      = '0;
            drop_d      = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            ptr_q       <= '0;
            slot_vld_q  <= '0;
            slot_code_q <= '0;
            judge_q     <= JUDGE_IDLE;
            lane_q      <= '0;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            ptr_q       <= ptr_d;
            slot_vld_q  <= slot_vld_d;
            slot_code_q <= slot_code_d;
            judge_q     <= judge_d;
            lane_q      <= lane_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
        end
    end

    assign o_judge = judge_q;
    assign o_lane  = lane_q;
    assign o_busy  = busy_q;
    assign o_drop  = drop_q;

endmodule

// File: tb/tb_judge_display_sched.sv
module tb_judge_display_sched;

    localparam int N = 4;
    localparam int H = 4;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] vld = '0;
    logic [7:0] jd = '0;
    logic [1:0] o_judge;
    logic [1:0] o_lane;
    logic       o_busy;
    logic       o_drop;

    logic       clr0 = 1'b0;
    logic [3:0] vld0 = '0;
    logic [7:0] jd0 = '0;
    logic [1:0] o0_judge;
    logic [1:0] o0_lane;
    logic       o0_busy;
    logic       o0_drop;

    judge_display_sched #(.N_LANES(N), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr), .i_judge_vld(vld),
        .i_judge(jd), .o_judge(o_judge), .o_lane(o_lane), .o_busy(o_busy),
        .o_drop(o_drop)
    );

    judge_display_sched #(.N_LANES(N), .HOLD_CYCLES(H), .GAP_CYCLES(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr0), .i_judge_vld(vld0),
        .i_judge(jd0), .o_judge(o0_judge), .o_lane(o0_lane), .o_busy(o0_busy),
        .o_drop(o0_drop)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int chks = 0;
    int drop_seen = 0;

    // Reference model: pending table plus "cycles left" counters for the
    // current display and the blank gap.
    bit         m_pv[N];
    logic [1:0] m_pc[N];
    int         m_rr, m_show, m_gap, m_lane;
    logic [1:0] m_code;
    logic       m_drop;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pv[i] = 1'b0;
            m_pc[i] = 2'b00;
        end
        m_rr = 0; m_show = 0; m_gap = 0; m_lane = 0; m_code = 2'b00; m_drop = 1'b0;
    endtask

    task automatic model_step();
        bit want;
        bit picked;
        int l;
        if (clr) begin
            model_reset();
        end else begin
            m_drop = 1'b0;
            want = 1'b0;
            picked = 1'b0;
            if (m_show > 0) begin
                m_show--;
                if (m_show == 0) begin
                    if (G > 0) m_gap = G;
                    else want = 1'b1;
                end
            end else if (m_gap > 0) begin
                m_gap--;
                if (m_gap == 0) want = 1'b1;
            end else begin
                want = 1'b1;
            end
            if (want) begin
                for (int i = 0; i < N; i++) begin
                    l = (m_rr + i) % N;
                    if (!picked && m_pv[l]) begin
                        picked = 1'b1;
                        m_code = m_pc[l];
                        m_lane = l;
                        m_show = H;
                        m_pv[l] = 1'b0;
                        m_rr = (l + 1) % N;
                    end
                end
            end
            for (int k = 0; k < N; k++) begin
                if (vld[k] && (jd[2*k +: 2] != 2'b00)) begin
                    if (m_pv[k]) m_drop = 1'b1;
                    m_pv[k] = 1'b1;
                    m_pc[k] = jd[2*k +: 2];
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".judge"}, 32'(o_judge), (m_show > 0) ? 32'(m_code) : 32'd0);
        check_val({tag, ".lane"},  32'(o_lane),  (m_show > 0) ? 32'(m_lane) : 32'd0);
        check_val({tag, ".busy"},  32'(o_busy),  32'((m_show > 0) || (m_gap > 0)));
        check_val({tag, ".drop"},  32'(o_drop),  32'(m_drop));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_outputs(tag);
        if (o_drop) drop_seen++;
        vld = '0; jd = '0; clr = 1'b0;
        vld0 = '0; jd0 = '0;
    endtask

    task automatic ev(input int lane, input logic [1:0] code);
        vld[lane] = 1'b1;
        jd[2*lane +: 2] = code;
    endtask

    logic [1:0] exp0_j[10];
    logic [1:0] exp0_l[10];

    initial begin
        model_reset();

        // Reset state
        #1;
        check_val("rst.judge", 32'(o_judge), 32'd0);
        check_val("rst.lane",  32'(o_lane),  32'd0);
        check_val("rst.busy",  32'(o_busy),  32'd0);
        check_val("rst.drop",  32'(o_drop),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick("idle");

        // Single event on lane 2, then hold, gap, idle
        ev(2, 2'b11);
        tick("l2_sample");
        tick("l2_show0");
        check_val("l2_first.judge", 32'(o_judge), 32'd3);
        check_val("l2_first.lane",  32'(o_lane),  32'd2);
        repeat (8) tick("l2_run");

        // Three lanes in the same cycle, no drops expected
        drop_seen = 0;
        ev(0, 2'b10); ev(1, 2'b01); ev(3, 2'b11);
        repeat (22) tick("three");
        check_val("three.drops", 32'(drop_seen), 32'd0);

        // Overwrite of lane 1 while lane 0 is showing
        drop_seen = 0;
        ev(0, 2'b11);
        tick("ow_l0");
        tick("ow_show");
        ev(1, 2'b01);
        tick("ow_a");
        ev(1, 2'b10);
        tick("ow_b");
        repeat (14) tick("ow_run");
        check_val("ow.drops", 32'(drop_seen), 32'd1);

        // Code 00 with strobe is ignored
        ev(2, 2'b00);
        repeat (3) tick("zero_code");
        check_val("zero.busy", 32'(o_busy), 32'd0);

        // Clear while lane 0 shows and lanes 1..3 pend; pointer returns to 0
        ev(0, 2'b01);
        tick("clr_l0");
        ev(1, 2'b10); ev(2, 2'b11); ev(3, 2'b01);
        tick("clr_pend");
        clr = 1'b1;
        tick("clr_pulse");
        check_val("clr.judge", 32'(o_judge), 32'd0);
        check_val("clr.busy",  32'(o_busy),  32'd0);
        repeat (6) tick("clr_quiet");
        ev(3, 2'b10);
        tick("clr_l3_sample");
        tick("clr_l3_show");
        check_val("clr_l3.lane", 32'(o_lane), 32'd3);
        repeat (8) tick("clr_l3_run");

        // Asynchronous reset in the middle of a display with a slot pending
        ev(1, 2'b10);
        tick("ar_l1");
        ev(3, 2'b11);
        tick("ar_show");
        #2;
        rst_n = 1'b0;
        #1;
        check_val("ar.judge", 32'(o_judge), 32'd0);
        check_val("ar.lane",  32'(o_lane),  32'd0);
        check_val("ar.busy",  32'(o_busy),  32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) tick("ar_after");

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 6) == 0) ev(k, 2'($urandom_range(0, 3)));
            end
            if ($urandom_range(0, 79) == 0) clr = 1'b1;
            tick("rand");
        end
        clr = 1'b1;
        tick("rand_end");

        // Back-to-back build: lanes 0 and 1 pending, no blank between them
        for (int i = 0; i < 10; i++) begin
            exp0_j[i] = (i >= 1 && i <= 4) ? 2'b10 : ((i >= 5 && i <= 8) ? 2'b01 : 2'b00);
            exp0_l[i] = (i >= 5 && i <= 8) ? 2'd1 : 2'd0;
        end
        vld0 = 4'b0011;
        jd0 = 8'b0000_0110;
        for (int i = 0; i < 10; i++) begin
            tick("b2b_main");
            check_val($sformatf("b2b[%0d].judge", i), 32'(o0_judge), 32'(exp0_j[i]));
            check_val($sformatf("b2b[%0d].lane", i),  32'(o0_lane),  32'(exp0_l[i]));
        end
        check_val("b2b.busy_end", 32'(o0_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
